// File: rtl/pipelined_add_sub.sv
// Streaming N-bit add/sub: carry chain cut into STAGES W-bit chunks, one chunk per stage, STAGES-cycle latency.
// Single advance enable (en = !out_valid || out_ready) stalls every stage at once; in_ready = en.
module pipelined_add_sub #(
  parameter int N      = 16,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] num1,
  input  logic [N-1:0] num2,
  input  logic         cin,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);
  localparam int W = N / STAGES;

  logic         en;
  logic [N-1:0] b_eff;
  logic         c_eff;

  always_comb begin
    en    = !out_valid || out_ready;
    b_eff = op ? ~num2 : num2;
    c_eff = op ? ~cin : cin;
  end

  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int RW   = N - k * W;
    localparam int DW   = (k + 1) * W;
    localparam bit LAST = (k == STAGES - 1);

    logic [RW-1:0] a_in, b_in;
    logic          c_in, v_in;
    logic [W:0]    chunk;
    logic          ld;
    logic          vld_d, vld_q;
    logic          cy_d, cy_q;
    logic [DW-1:0] res_d, res_q;

    // Operands still waiting for their carry arrive through the previous stage's skew registers.
    if (k == 0) begin : g_src
      always_comb begin
        a_in = num1;
        b_in = b_eff;
        c_in = c_eff;
        v_in = in_valid;
      end
      always_comb res_d = chunk[W-1:0];
    end else begin : g_src
      always_comb begin
        a_in = g_stg[k-1].g_fwd.a_q;
        b_in = g_stg[k-1].g_fwd.b_q;
        c_in = g_stg[k-1].cy_q;
        v_in = g_stg[k-1].vld_q;
      end
      always_comb res_d = {chunk[W-1:0], g_stg[k-1].res_q};
    end

    // The output stage only captures real results so the outputs hold across bubbles.
    always_comb begin
      chunk = {1'b0, a_in[W-1:0]} + {1'b0, b_in[W-1:0]} + {{W{1'b0}}, c_in};
      cy_d  = chunk[W];
      vld_d = v_in;
      ld    = en && (v_in || !LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        res_q <= '0;
      end else begin
        if (en) vld_q <= vld_d;
        if (ld) begin
          cy_q  <= cy_d;
          res_q <= res_d;
        end
      end
    end

    if (!LAST) begin : g_fwd
      logic [RW-W-1:0] a_d, a_q, b_d, b_q;

      always_comb begin
        a_d = a_in[RW-1:W];
        b_d = b_in[RW-1:W];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_last
      logic ovf_d, ovf_q, zero_d, zero_q;

      // The top chunk carries the sign bits of A and B'.
      always_comb begin
        ovf_d  = (a_in[W-1] == b_in[W-1]) && (chunk[W-1] != a_in[W-1]);
        zero_d = (res_d == '0);
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (ld) begin
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end
    end
  end

  always_comb begin
    out_valid = g_stg[STAGES-1].vld_q;
    sum       = g_stg[STAGES-1].res_q;
    cout      = g_stg[STAGES-1].cy_q;
    ovf       = g_stg[STAGES-1].g_last.ovf_q;
    zero      = g_stg[STAGES-1].g_last.zero_q;
  end

endmodule
